// File: rtl/dunit_ctrl.sv
// Debug-unit controller: byte-wide host link that loads instruction memory,
// runs or single-steps the pipeline, and dumps registers and data memory.
module dunit_ctrl #(
    parameter int NB_REG   = 32,
    parameter int NB_WIDHT = 9,
    parameter int N_REGS   = 32,
    parameter int N_MEM    = 16
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [7:0]          i_rx_data,
    input  logic                i_rx_valid,
    output logic [7:0]          o_tx_data,
    output logic                o_tx_valid,
    input  logic                i_tx_ready,
    output logic                o_dunit_clk_en,
    output logic                o_dunit_reset_pc,
    output logic                o_dunit_w_mem,
    output logic [NB_WIDHT-1:0] o_dunit_addr,
    output logic [NB_REG-1:0]   o_dunit_data_if,
    input  logic [NB_REG-1:0]   i_dunit_reg,
    input  logic [NB_REG-1:0]   i_dunit_mem_data,
    input  logic                i_halt
);

    localparam int NBYTES  = NB_REG / 8;
    localparam int N_ITEMS = N_REGS + N_MEM;

    typedef enum logic [3:0] {
        IDLE, LOAD_CNT, LOAD_BYTE, LOAD_WR, RUN, STEP, DUMP_ADDR, DUMP_WAIT, DUMP_SEND
    } state_t;

    state_t                state_q, state_d;
    logic [7:0]            cnt_q;        // words still to be loaded (as received)
    logic [15:0]           idx_q;        // load word index or dump item index
    logic [7:0]            byte_q;       // byte position inside the current word
    logic [NB_REG-1:0]     word_q;       // load assembly register
    logic [NB_REG-1:0]     shift_q;      // dump word, shifted out MSB first
    logic [NB_WIDHT-1:0]   addr_q;
    logic                  post_load_q;  // keeps reset_pc up one cycle after the last write

    logic byte_last;
    logic word_last;
    logic item_last;

    assign byte_last = (byte_q == 8'(NBYTES - 1));
    assign word_last = ((idx_q + 16'd1) == {8'd0, cnt_q});
    assign item_last = (idx_q == 16'(N_ITEMS - 1));

    // Word index to byte address; upper bits fall off so the address wraps.
    function automatic logic [NB_WIDHT-1:0] word_addr(input logic [15:0] idx);
        return NB_WIDHT'({idx, 2'b00});
    endfunction

    // Dump item index to debug address: registers first, then memory words.
    function automatic logic [NB_WIDHT-1:0] item_addr(input logic [15:0] idx);
        if (idx < 16'(N_REGS))
            return NB_WIDHT'(idx);
        return word_addr(idx - 16'(N_REGS));
    endfunction

    // State register.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state decode and per-state control outputs.
    always_comb begin
        state_d          = state_q;
        o_tx_valid       = 1'b0;
        o_dunit_w_mem    = 1'b0;
        o_dunit_clk_en   = 1'b0;
        o_dunit_reset_pc = post_load_q;
        case (state_q)
            IDLE: begin
                if (i_rx_valid) begin
                    if (i_rx_data == 8'h4C)      state_d = LOAD_CNT;
                    else if (i_rx_data == 8'h52) state_d = RUN;
                    else if (i_rx_data == 8'h53) state_d = STEP;
                end
            end
            LOAD_CNT: begin
                o_dunit_reset_pc = 1'b1;
                if (i_rx_valid) state_d = (i_rx_data == 8'h00) ? IDLE : LOAD_BYTE;
            end
            LOAD_BYTE: begin
                o_dunit_reset_pc = 1'b1;
                if (i_rx_valid && byte_last) state_d = LOAD_WR;
            end
            LOAD_WR: begin
                o_dunit_reset_pc = 1'b1;
                o_dunit_w_mem    = 1'b1;
                state_d          = word_last ? IDLE : LOAD_BYTE;
            end
            RUN: begin
                o_dunit_clk_en = 1'b1;
                if (i_halt || (i_rx_valid && i_rx_data == 8'h48)) state_d = DUMP_ADDR;
            end
            STEP: begin
                o_dunit_clk_en = 1'b1;
                state_d        = DUMP_ADDR;
            end
            DUMP_ADDR: state_d = DUMP_WAIT;
            DUMP_WAIT: state_d = DUMP_SEND;
            DUMP_SEND: begin
                o_tx_valid = 1'b1;
                if (i_tx_ready && byte_last) state_d = item_last ? IDLE : DUMP_ADDR;
            end
            default: state_d = IDLE;
        endcase
    end

    // Counters, load assembly, dump capture/shift and debug address.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            byte_q      <= '0;
            word_q      <= '0;
            shift_q     <= '0;
            addr_q      <= '0;
            post_load_q <= 1'b0;
        end else begin
            post_load_q <= (state_q == LOAD_WR) && word_last;
            case (state_q)
                LOAD_CNT: begin
                    if (i_rx_valid) begin
                        cnt_q  <= i_rx_data;
                        idx_q  <= '0;
                        byte_q <= '0;
                    end
                end
                LOAD_BYTE: begin
                    if (i_rx_valid) begin
                        word_q <= (word_q << 8) | NB_REG'(i_rx_data);
                        if (byte_last) begin
                            byte_q <= '0;
                            addr_q <= word_addr(idx_q);
                        end else begin
                            byte_q <= byte_q + 8'd1;
                        end
                    end
                end
                LOAD_WR: idx_q <= idx_q + 16'd1;
                RUN, STEP: begin
                    if (state_d == DUMP_ADDR) begin
                        idx_q  <= '0;
                        byte_q <= '0;
                        addr_q <= item_addr(16'd0);
                    end
                end
                DUMP_WAIT: begin
                    shift_q <= (idx_q < 16'(N_REGS)) ? i_dunit_reg : i_dunit_mem_data;
                    byte_q  <= '0;
                end
                DUMP_SEND: begin
                    if (i_tx_ready) begin
                        shift_q <= shift_q << 8;
                        if (byte_last) begin
                            byte_q <= '0;
                            idx_q  <= idx_q + 16'd1;
                            addr_q <= item_addr(idx_q + 16'd1);
                        end else begin
                            byte_q <= byte_q + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_tx_data       = shift_q[NB_REG-1 -: 8];
    assign o_dunit_addr    = addr_q;
    assign o_dunit_data_if = word_q;

endmodule

// File: tb/tb_dunit_ctrl.sv
// Randomized bench for dunit_ctrl against a transaction-level reference model.
module tb_dunit_ctrl;

    localparam int NB_REG   = 32;
    localparam int NB_WIDHT = 9;
    localparam int N_REGS   = 32;
    localparam int N_MEM    = 16;

    logic                i_clk = 1'b0;
    logic                i_reset = 1'b0;
    logic [7:0]          i_rx_data = '0;
    logic                i_rx_valid = 1'b0;
    logic [7:0]          o_tx_data;
    logic                o_tx_valid;
    logic                i_tx_ready = 1'b1;
    logic                o_dunit_clk_en;
    logic                o_dunit_reset_pc;
    logic                o_dunit_w_mem;
    logic [NB_WIDHT-1:0] o_dunit_addr;
    logic [NB_REG-1:0]   o_dunit_data_if;
    logic [NB_REG-1:0]   i_dunit_reg = '0;
    logic [NB_REG-1:0]   i_dunit_mem_data = '0;
    logic                i_halt = 1'b0;

    dunit_ctrl #(.NB_REG(NB_REG), .NB_WIDHT(NB_WIDHT), .N_REGS(N_REGS), .N_MEM(N_MEM)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
        .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
        .o_dunit_clk_en(o_dunit_clk_en), .o_dunit_reset_pc(o_dunit_reset_pc),
        .o_dunit_w_mem(o_dunit_w_mem), .o_dunit_addr(o_dunit_addr),
        .o_dunit_data_if(o_dunit_data_if), .i_dunit_reg(i_dunit_reg),
        .i_dunit_mem_data(i_dunit_mem_data), .i_halt(i_halt)
    );

    initial forever #5 i_clk = ~i_clk;

    int checks = 0;
    int failures = 0;

    logic [31:0] reg_val [N_REGS];
    logic [31:0] mem_val [N_MEM];
    logic [31:0] load_words [$];
    logic [NB_WIDHT-1:0] wr_addr_q [$];
    logic [NB_REG-1:0]   wr_data_q [$];
    logic [7:0] tx_q [$];
    logic [7:0] exp_q [$];
    int  clk_cnt = 0, rpc_cnt = 0, rpc_viol = 0, mutex_viol = 0, stall_viol = 0;
    bit  rnd_ready = 1'b0;

    logic [52:0] outs_w;
    assign outs_w = {o_tx_valid, o_dunit_clk_en, o_dunit_w_mem, o_dunit_reset_pc,
                     o_dunit_addr, o_dunit_data_if, o_tx_data};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Synchronous register file / data memory: data follows the address one cycle later.
    initial begin
        logic [NB_WIDHT-1:0] prev_addr;
        prev_addr = '0;
        forever begin
            @(posedge i_clk);
            #1;
            i_dunit_reg      = reg_val[prev_addr[4:0]];
            i_dunit_mem_data = mem_val[prev_addr[5:2]];
            prev_addr        = o_dunit_addr;
        end
    end

    // Host tx ready: always ready or random backpressure.
    initial forever begin
        @(posedge i_clk);
        #1;
        i_tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Output monitor, sampled mid-cycle.
    initial begin
        bit held;
        logic [7:0] held_data;
        held = 1'b0;
        held_data = '0;
        forever begin
            @(negedge i_clk);
            if (o_dunit_w_mem) begin
                wr_addr_q.push_back(o_dunit_addr);
                wr_data_q.push_back(o_dunit_data_if);
                if (!o_dunit_reset_pc) rpc_viol++;
            end
            if (o_dunit_w_mem && o_dunit_clk_en) mutex_viol++;
            if (o_dunit_clk_en) clk_cnt++;
            if (o_dunit_reset_pc) rpc_cnt++;
            if (held && (!o_tx_valid || o_tx_data !== held_data)) stall_viol++;
            if (o_tx_valid && i_tx_ready) begin
                tx_q.push_back(o_tx_data);
                held = 1'b0;
            end else if (o_tx_valid) begin
                held = 1'b1;
                held_data = o_tx_data;
            end else begin
                held = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        tick();
        i_rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit noisy);
        for (int b = 0; b < 4; b++) begin
            if (noisy) repeat ($urandom_range(0, 2)) tick();
            send_byte(w[31 - 8*b -: 8]);
        end
        // One cycle for the write; a byte sent here must be dropped.
        if (noisy && $urandom_range(0, 1) == 1) send_byte(8'($urandom));
        else tick();
    endtask

    task automatic do_load(input bit noisy);
        send_byte(8'h4C);
        send_byte(8'(load_words.size()));
        foreach (load_words[i]) send_word(load_words[i], noisy);
    endtask

    task automatic check_writes(input string tag);
        int n;
        n = wr_addr_q.size();
        check({tag, "_count"}, 64'(n), 64'(load_words.size()));
        for (int i = 0; i < n && i < load_words.size(); i++) begin
            check({tag, "_addr"}, 64'(wr_addr_q[i]), 64'((i * 4) % (1 << NB_WIDHT)));
            check({tag, "_data"}, 64'(wr_data_q[i]), 64'(load_words[i]));
        end
    endtask

    task automatic random_state();
        foreach (reg_val[i]) reg_val[i] = $urandom;
        foreach (mem_val[i]) mem_val[i] = $urandom;
    endtask

    // Waits for a full dump (noise on rx meanwhile) and compares it with the model.
    task automatic dump_check(input string tag);
        int n, nbad, first;
        exp_q.delete();
        for (int i = 0; i < N_REGS; i++)
            for (int b = 3; b >= 0; b--) exp_q.push_back(8'(reg_val[i] >> (8 * b)));
        for (int i = 0; i < N_MEM; i++)
            for (int b = 3; b >= 0; b--) exp_q.push_back(8'(mem_val[i] >> (8 * b)));
        n = 0;
        while (tx_q.size() < exp_q.size() && n < 20000) begin
            i_rx_valid = ($urandom_range(0, 3) == 0);
            i_rx_data  = 8'($urandom);
            tick();
            n++;
        end
        i_rx_valid = 1'b0;
        repeat (8) tick();
        check({tag, "_len"}, 64'(tx_q.size()), 64'(exp_q.size()));
        nbad = 0;
        first = -1;
        for (int i = 0; i < tx_q.size() && i < exp_q.size(); i++)
            if (tx_q[i] !== exp_q[i]) begin
                nbad++;
                if (first < 0) first = i;
            end
        check({tag, "_bad_bytes"}, 64'(nbad), 64'(0));
        if (first >= 0)
            $display("  %s first differing byte %0d: got %02h expected %02h",
                     tag, first, tx_q[first], exp_q[first]);
        check({tag, "_tx_idle"}, 64'(o_tx_valid), 64'(0));
        tx_q.delete();
    endtask

    initial begin
        int d;
        random_state();

        // Reset state
        repeat (3) tick();
        check("rst_outputs", 64'(outs_w), 64'(0));
        i_reset = 1'b1;
        tick();

        // Unknown commands in IDLE are ignored
        send_byte(8'h00); send_byte(8'h48); send_byte(8'hFF); send_byte(8'h41);
        repeat (3) tick();
        check("idle_junk_wr", 64'(wr_addr_q.size()), 64'(0));
        check("idle_junk_clk", 64'(clk_cnt), 64'(0));
        check("idle_junk_tx", 64'(tx_q.size()), 64'(0));

        // Two-word load, back to back
        load_words = '{32'h20010001, 32'h20020002};
        rpc_cnt = 0;
        do_load(1'b0);
        repeat (2) tick();
        check_writes("load2");
        check("load2_rpc_cycles", 64'(rpc_cnt), 64'(5 * 2 + 2));
        check("load2_rpc_low", 64'(o_dunit_reset_pc), 64'(0));

        // Zero-length load, then STEP must be accepted
        wr_addr_q.delete(); wr_data_q.delete();
        send_byte(8'h4C); send_byte(8'h00);
        tick();
        check("load0_wr", 64'(wr_addr_q.size()), 64'(0));
        foreach (reg_val[i]) reg_val[i] = 32'(i) + 32'h100;
        foreach (mem_val[i]) mem_val[i] = 32'hA5A5A5A5;
        clk_cnt = 0;
        send_byte(8'h53);
        dump_check("step");
        check("step_clk_en", 64'(clk_cnt), 64'(1));

        // RUN stopped by halt raised in the 7th cycle, random backpressure
        random_state();
        rnd_ready = 1'b1;
        clk_cnt = 0;
        send_byte(8'h52);
        repeat (6) tick();
        i_halt = 1'b1;
        tick();
        i_halt = 1'b0;
        dump_check("run_halt");
        check("run_halt_clk_en", 64'(clk_cnt), 64'(7));

        // RUN aborted by 'H' after a random number of cycles
        random_state();
        d = $urandom_range(1, 10);
        clk_cnt = 0;
        send_byte(8'h52);
        repeat (d - 1) tick();
        send_byte(8'h48);
        dump_check("run_abort");
        check("run_abort_clk_en", 64'(clk_cnt), 64'(d));

        // STEP with halt held high: still exactly one advance
        random_state();
        clk_cnt = 0;
        i_halt = 1'b1;
        send_byte(8'h53);
        i_halt = 1'b0;
        dump_check("step_halt");
        check("step_halt_clk_en", 64'(clk_cnt), 64'(1));
        rnd_ready = 1'b0;

        // Long noisy load: address wraps past 2^NB_WIDHT
        load_words.delete();
        repeat (130) load_words.push_back($urandom);
        wr_addr_q.delete(); wr_data_q.delete();
        do_load(1'b1);
        repeat (2) tick();
        check_writes("load130");

        // Reset in the middle of the third word
        load_words.delete();
        repeat (3) load_words.push_back($urandom);
        wr_addr_q.delete(); wr_data_q.delete();
        send_byte(8'h4C); send_byte(8'h03);
        send_word(load_words[0], 1'b0);
        send_word(load_words[1], 1'b0);
        send_byte(load_words[2][31:24]);
        send_byte(load_words[2][23:16]);
        #2;
        i_reset = 1'b0;
        #1;
        check("rst_mid_outputs", 64'(outs_w), 64'(0));
        check("rst_mid_wr_before", 64'(wr_addr_q.size()), 64'(2));
        repeat (3) tick();
        i_reset = 1'b1;
        repeat (3) tick();
        check("rst_mid_wr_after", 64'(wr_addr_q.size()), 64'(2));

        // Fresh load after reset
        load_words.delete();
        repeat (2) load_words.push_back($urandom);
        wr_addr_q.delete(); wr_data_q.delete();
        do_load(1'b1);
        repeat (2) tick();
        check_writes("reload");

        check("wmem_clken_overlap", 64'(mutex_viol), 64'(0));
        check("tx_stall_unstable", 64'(stall_viol), 64'(0));
        check("wmem_without_rpc", 64'(rpc_viol), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
